// File: rtl/pe_types.sv
// Shared types and derived-size helpers for the PE result drain path.
// Used by pe_result_drain and pe_drain_fifo.
package pe_types;

  typedef struct packed {
    int unsigned result_width;
    int unsigned num_results;
    int unsigned odata_width;
  } pe_cfg_t;

  localparam int unsigned RESULT_WIDTH_DEF = 16;

  typedef logic [RESULT_WIDTH_DEF-1:0] result_t;

  typedef enum logic {
    IDLE,
    PACKING
  } pack_state_e;

  function automatic int unsigned beat_w(pe_cfg_t c);
    return c.result_width * c.num_results;
  endfunction

  function automatic int unsigned beats_per_word(pe_cfg_t c);
    int unsigned bw;
    bw = beat_w(c);
    return (bw == 0) ? 0 : c.odata_width / bw;
  endfunction

endpackage

// File: rtl/pe_drain_fifo.sv
// Synchronous FIFO of {last, word} entries with flush and
// push-while-full acceptance when the head pops in the same cycle.
module pe_drain_fifo
  import pe_types::*;
#(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         rready,
  output logic         rvalid,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         drop
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wp;
  logic [AW:0]  rp;
  logic         empty;
  logic         pop;
  logic         wr;

  assign empty  = (wp == rp);
  assign full   = (wp[AW] != rp[AW]) &&
                  (wp[AW-1:0] == rp[AW-1:0]);
  assign pop    = rready & ~empty;
  assign wr     = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign rvalid = ~empty;
  assign rdata  = empty ? '0 : mem[rp[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wp <= '0;
      rp <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr)  wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: rdata is masked while empty.
  always_ff @(posedge clock) begin
    if (wr && !flush) mem[wp[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/pe_result_drain.sv
// Packs PE drain beats into output words and buffers them in a FIFO.
// Define PE_DRAIN_PERF_EN to add the stall_count output and counter.
module pe_result_drain
  import pe_types::*;
#(
  parameter int unsigned RESULT_WIDTH          = 16,
  parameter int unsigned NUM_RESULTS_PER_CYCLE = 6,
  parameter int unsigned ODATA_WIDTH           = 384,
  parameter int unsigned FIFO_DEPTH            = 4,
  localparam pe_cfg_t    CFG = '{
    result_width: RESULT_WIDTH,
    num_results:  NUM_RESULTS_PER_CYCLE,
    odata_width:  ODATA_WIDTH
  },
  localparam int unsigned BEAT_W = beat_w(CFG)
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   clear,
  input  logic                   in_valid,
  input  logic                   in_last,
  input  logic [BEAT_W-1:0]      in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ODATA_WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic                   overflow
`ifdef PE_DRAIN_PERF_EN
  ,
  output logic [31:0]            stall_count
`endif
);

  localparam int unsigned BPW = beats_per_word(CFG);
  localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

  if (BPW == 0 || BPW * BEAT_W != ODATA_WIDTH) begin : g_bad_cfg
    $error("ODATA_WIDTH must be a nonzero multiple of BEAT_W");
  end

  pack_state_e            state_q, state_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [ODATA_WIDTH-1:0] pack_q, pack_d;
  logic [ODATA_WIDTH-1:0] word_c;
  logic                   accept;
  logic                   done;
  logic                   drop;
  logic                   fifo_full;

  assign accept = in_valid & ~clear;
  assign done   = accept &
                  (in_last | (cnt_q == CW'(BPW - 1)));

  // Completed word = registered slices plus the current beat.
  always_comb begin
    word_c = pack_q;
    word_c[int'(cnt_q) * BEAT_W +: BEAT_W] = in_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pack_d  = pack_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      pack_d  = '0;
    end else if (accept) begin
      if (done) begin
        state_d = IDLE;
        cnt_d   = '0;
        pack_d  = '0;
      end else begin
        state_d = PACKING;
        cnt_d   = cnt_q + CW'(1);
        pack_d  = word_c;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pack_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pack_q  <= pack_d;
    end
  end

  pe_drain_fifo #(
    .W     (ODATA_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock  (clock),
    .resetn (resetn),
    .flush  (clear),
    .push   (done),
    .wdata  ({in_last, word_c}),
    .rready (out_ready),
    .rvalid (out_valid),
    .rdata  ({out_last, out_data}),
    .full   (fifo_full),
    .drop   (drop)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)    overflow <= 1'b0;
    else if (clear) overflow <= 1'b0;
    else if (drop)  overflow <= 1'b1;
  end

`ifdef PE_DRAIN_PERF_EN
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      stall_count <= '0;
    end else if (clear) begin
      stall_count <= '0;
    end else if (out_valid && !out_ready &&
                 stall_count != '1) begin
      stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: drain table plus
// corner-case sequences, scoreboard-checked at the output port.
module tb_pe_result_drain;

  localparam int BW = 96;
  localparam int OW = 384;

  logic          clock = 1'b0;
  logic          resetn;
  logic          clear;
  logic          in_valid;
  logic          in_last;
  logic [BW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;
  logic          overflow;
`ifdef PE_DRAIN_PERF_EN
  logic [31:0]   stall_count;
`endif

  int checks = 0;
  int passed = 0;
  logic [OW:0] sb[$];

  always #5 clock = ~clock;

  pe_result_drain dut (
    .clock     (clock),
    .resetn    (resetn),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .overflow  (overflow)
`ifdef PE_DRAIN_PERF_EN
    ,
    .stall_count (stall_count)
`endif
  );

  task automatic chk(input string nm, input logic [OW:0] act,
                     input logic [OW:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [BW-1:0] gen(input logic [15:0] base,
                                        input int b);
    logic [BW-1:0] r;
    for (int l = 0; l < 6; l++) r[l*16 +: 16] = base + 16'(b*6 + l);
    return r;
  endfunction

  function automatic logic [OW-1:0] expw(input logic [15:0] base,
                                         input int n);
    logic [OW-1:0] w;
    w = '0;
    for (int b = 0; b < n; b++) w[b*BW +: BW] = gen(base, b);
    return w;
  endfunction

  task automatic beat(input logic [BW-1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = '0;
  endtask

  task automatic drain(input logic [15:0] base, input int n,
                       input logic l);
    for (int b = 0; b < n; b++) beat(gen(base, b), l && (b == n-1));
  endtask

  task automatic expect_word(input logic [15:0] base, input int n,
                             input logic l);
    sb.push_back({l, expw(base, n)});
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_done", (OW+1)'(sb.size()), '0);
  endtask

  always @(negedge clock) begin
    if (resetn && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_word: got %h want none",
                 {out_last, out_data});
      end else begin
        chk("word", {out_last, out_data}, sb.pop_front());
      end
    end
  end

  typedef struct {
    int         nbeats;
    logic       last;
    logic [15:0] base;
    logic       exp_last;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{4, 1'b0, 16'h0100, 1'b0};
    tbl[1] = '{4, 1'b1, 16'h0200, 1'b1};
    tbl[2] = '{1, 1'b1, 16'h0300, 1'b1};
    tbl[3] = '{2, 1'b1, 16'h0400, 1'b1};
    tbl[4] = '{3, 1'b1, 16'h0500, 1'b1};
    tbl[5] = '{4, 1'b0, 16'h0600, 1'b0};

    resetn = 1'b0; clear = 1'b0; in_valid = 1'b0;
    in_last = 1'b0; in_data = '0; out_ready = 1'b0;
    #12;
    chk("rst_valid", (OW+1)'(out_valid), '0);
    chk("rst_data", (OW+1)'(out_data), '0);
    chk("rst_last", (OW+1)'(out_last), '0);
    chk("rst_ovf", (OW+1)'(overflow), '0);
`ifdef PE_DRAIN_PERF_EN
    chk("rst_stall", (OW+1)'(stall_count), '0);
`endif
    @(posedge clock); #1;
    resetn = 1'b1;
    out_ready = 1'b1;

    // Four beats of lanes 0x0001..0x0018
    expect_word(16'h0001, 4, 1'b0);
    drain(16'h0001, 3, 1'b0);
    chk("t1_not_yet", (OW+1)'(out_valid), '0);
    beat(gen(16'h0001, 3), 1'b0);
    chk("t1_latency", (OW+1)'(out_valid), (OW+1)'(1));
    chk("t1_lo", (OW+1)'(out_data[15:0]), (OW+1)'(16'h0001));
    chk("t1_hi", (OW+1)'(out_data[383:368]), (OW+1)'(16'h0018));
    chk("t1_last", (OW+1)'(out_last), '0);
    wait_empty();

    // Partial word closed by in_last, then a fresh drain
    expect_word(16'h0020, 3, 1'b1);
    drain(16'h0020, 3, 1'b1);
    chk("t2_pad", (OW+1)'(out_data[383:288]), '0);
    chk("t2_last", (OW+1)'(out_last), (OW+1)'(1));
    expect_word(16'h0040, 4, 1'b0);
    drain(16'h0040, 4, 1'b0);
    wait_empty();

    // Table of back-to-back drains
    for (int i = 0; i < 6; i++) begin
      expect_word(tbl[i].base, tbl[i].nbeats, tbl[i].exp_last);
      drain(tbl[i].base, tbl[i].nbeats, tbl[i].last);
    end
    wait_empty();

    // Overflow: five words into a four-entry FIFO
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) expect_word(16'h1000 + 16'(i*64), 4, 1'b0);
      drain(16'h1000 + 16'(i*64), 4, 1'b0);
      if (i == 3) chk("ovf_before", (OW+1)'(overflow), '0);
    end
    chk("ovf_set", (OW+1)'(overflow), (OW+1)'(1));
    out_ready = 1'b1;
    wait_empty();
    chk("ovf_sticky", (OW+1)'(overflow), (OW+1)'(1));

    // Clear with a buffered word, a partial word and a same-cycle beat
    out_ready = 1'b0;
    drain(16'h2000, 4, 1'b0);
    beat(gen(16'h2100, 0), 1'b0);
    clear = 1'b1;
    beat(gen(16'h2200, 0), 1'b1);
    clear = 1'b0;
    chk("clr_ovf", (OW+1)'(overflow), '0);
    chk("clr_valid", (OW+1)'(out_valid), '0);
    out_ready = 1'b1;
    expect_word(16'h2300, 4, 1'b0);
    drain(16'h2300, 4, 1'b0);
    wait_empty();

    // Full FIFO with a pop on the completing beat
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      expect_word(16'h3000 + 16'(i*64), 4, 1'b0);
      drain(16'h3000 + 16'(i*64), 4, 1'b0);
    end
    expect_word(16'h3400, 4, 1'b1);
    drain(16'h3400, 3, 1'b0);
    out_ready = 1'b1;
    beat(gen(16'h3400, 3), 1'b1);
    chk("fullpop_ovf", (OW+1)'(overflow), '0);
    wait_empty();

    // Asynchronous reset mid-pack
    out_ready = 1'b0;
    drain(16'h4000, 4, 1'b0);
    drain(16'h4100, 2, 1'b0);
    chk("pre_rst_valid", (OW+1)'(out_valid), (OW+1)'(1));
    #2 resetn = 1'b0;
    #1;
    chk("arst_valid", (OW+1)'(out_valid), '0);
    chk("arst_data", (OW+1)'(out_data), '0);
    chk("arst_last", (OW+1)'(out_last), '0);
    @(posedge clock); #1;
    resetn = 1'b1;
    out_ready = 1'b1;
    expect_word(16'h4200, 4, 1'b0);
    drain(16'h4200, 4, 1'b0);
    wait_empty();

`ifdef PE_DRAIN_PERF_EN
    out_ready = 1'b0;
    expect_word(16'h5000, 4, 1'b0);
    drain(16'h5000, 4, 1'b0);
    repeat (7) @(posedge clock);
    #1;
    chk("stall7", (OW+1)'(stall_count), (OW+1)'(7));
    out_ready = 1'b1;
    wait_empty();
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    chk("stall_clr", (OW+1)'(stall_count), '0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
